// File: rtl/mux81_scan_ctrl.sv
// Sequencer for an external 8-to-1 mux: walks the selects through channels 0..7,
// samples Y after a settle time on each one, and hands the assembled byte downstream.
module mux81_scan_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  output logic       BUSY,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic       ENb,
  input  logic       Y,
  output logic [7:0] DOUT,
  output logic       DVALID,
  input  logic       DREADY
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t      state_reg, state_next;
  logic [2:0]  sel_reg, sel_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  dout_reg, dout_next;
  logic        dvalid_reg, dvalid_next;
  logic        enb_reg, enb_next;
  logic        busy_reg, busy_next;
  logic [7:0]  captured;

  // Shift register image with the current channel's bit replaced by Y.
  for (genvar gi = 0; gi < 8; gi++) begin : g_capture
    assign captured[gi] = (sel_reg == 3'(gi)) ? Y : shift_reg[gi];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= ST_IDLE;
      sel_reg    <= 3'd0;
      cnt_reg    <= 4'd0;
      shift_reg  <= 8'h00;
      dout_reg   <= 8'h00;
      dvalid_reg <= 1'b0;
      enb_reg    <= 1'b1;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      cnt_reg    <= cnt_next;
      shift_reg  <= shift_next;
      dout_reg   <= dout_next;
      dvalid_reg <= dvalid_next;
      enb_reg    <= enb_next;
      busy_reg   <= busy_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    cnt_next    = cnt_reg;
    shift_next  = shift_reg;
    dout_next   = dout_reg;
    dvalid_next = dvalid_reg;
    enb_next    = enb_reg;

    case (state_reg)
      ST_IDLE: begin
        if (START) begin
          state_next = ST_SETTLE;
          sel_next   = 3'd0;
          cnt_next   = 4'd0;
          enb_next   = 1'b0;
          shift_next = 8'h00;
        end
      end
      ST_SETTLE: begin
        if (cnt_reg == CNT_LAST) begin
          state_next = ST_SAMPLE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      ST_SAMPLE: begin
        shift_next = captured;
        if (sel_reg == 3'd7) begin
          state_next  = ST_DONE;
          dout_next   = captured;
          dvalid_next = 1'b1;
          enb_next    = 1'b1;
          sel_next    = 3'd0;
        end else begin
          state_next = ST_SETTLE;
          sel_next   = sel_reg + 3'd1;
          cnt_next   = 4'd0;
        end
      end
      ST_DONE: begin
        // A START coinciding with the handshake chains straight into the next scan.
        if (DREADY) begin
          dvalid_next = 1'b0;
          if (START) begin
            state_next = ST_SETTLE;
            sel_next   = 3'd0;
            cnt_next   = 4'd0;
            enb_next   = 1'b0;
            shift_next = 8'h00;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  assign S0     = sel_reg[0];
  assign S1     = sel_reg[1];
  assign S2     = sel_reg[2];
  assign ENb    = enb_reg;
  assign DOUT   = dout_reg;
  assign DVALID = dvalid_reg;
  assign BUSY   = busy_reg;

endmodule

// File: tb/tb_mux81_scan_ctrl.sv
// Bench for mux81_scan_ctrl: a mux model feeds Y, and expected selects, latency and bytes
// are derived from the per-channel period (SETTLE+1) and the byte being scanned.
module tb_mux81_scan_ctrl;

  localparam int PER = 3;         // SETTLE=2 build: cycles per channel
  localparam int LAT = 8 * PER;   // START edge to DVALID
  localparam int LAT2 = 8 * 2;    // SETTLE=1 build

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, dready, y;
  logic       busy, s0, s1, s2, enb, dvalid;
  logic [7:0] dout;
  logic [2:0] sel;

  logic       start2, dready2, y2;
  logic       busy2, s0_2, s1_2, s2_2, enb2, dvalid2;
  logic [7:0] dout2;
  logic [2:0] sel2;

  logic [7:0] d_model, d2_model;
  logic       noisy, y_noise;

  int n_cmp = 0;
  int n_err = 0;

  assign sel  = {s2, s1, s0};
  assign sel2 = {s2_2, s1_2, s0_2};
  assign y    = noisy ? y_noise : (enb ? 1'b0 : d_model[sel]);
  assign y2   = enb2 ? 1'b0 : d2_model[sel2];

  mux81_scan_ctrl #(.SETTLE(2)) dut (
    .CLK(clk), .RST(rst), .START(start), .BUSY(busy),
    .S0(s0), .S1(s1), .S2(s2), .ENb(enb), .Y(y),
    .DOUT(dout), .DVALID(dvalid), .DREADY(dready)
  );

  mux81_scan_ctrl #(.SETTLE(1)) dut2 (
    .CLK(clk), .RST(rst), .START(start2), .BUSY(busy2),
    .S0(s0_2), .S1(s1_2), .S2(s2_2), .ENb(enb2), .Y(y2),
    .DOUT(dout2), .DVALID(dvalid2), .DREADY(dready2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a scan from IDLE and follows it to DONE, checking the select walk.
  // With use_noise, Y carries junk except in the cycle just before each sample edge.
  task automatic run_scan(input logic [7:0] data, input logic use_noise);
    d_model = data;
    noisy   = use_noise;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int j = 0; j < LAT; j++) begin
      n_cmp++;
      if ({busy, enb, dvalid, sel} !== {1'b1, 1'b0, 1'b0, 3'(j / PER)}) begin
        n_err++;
        $display("FAIL walk j=%0d: busy/enb/dvalid/sel got %b%b%b/%0d required 100/%0d",
                 j, busy, enb, dvalid, sel, j / PER);
      end
      y_noise = (j % PER == PER - 1) ? data[j / PER] : 1'($urandom);
      tick();
    end
    n_cmp++;
    if ({dvalid, enb, busy, sel, dout} !== {1'b1, 1'b1, 1'b1, 3'd0, data}) begin
      n_err++;
      $display("FAIL scan_done: dvalid/enb/busy/sel/dout got %b%b%b/%0d/%h required 111/0/%h",
               dvalid, enb, busy, sel, dout, data);
    end
    noisy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dready = 1'b0; start2 = 1'b0; dready2 = 1'b0;
    noisy = 1'b0; y_noise = 1'b0; d_model = 8'h00; d2_model = 8'h00;
    tick();
    tick();
    n_cmp++;
    if ({busy, sel, enb, dout, dvalid} !== {1'b0, 3'd0, 1'b1, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL reset: busy/sel/enb/dout/dvalid got %b/%0d/%b/%h/%b required 0/0/1/00/0",
               busy, sel, enb, dout, dvalid);
    end
    n_cmp++;
    if ({busy2, sel2, enb2, dout2, dvalid2} !== {1'b0, 3'd0, 1'b1, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL reset2: busy/sel/enb/dout/dvalid got %b/%0d/%b/%h/%b required 0/0/1/00/0",
               busy2, sel2, enb2, dout2, dvalid2);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_scan(8'hA5, 1'b0);
    dready = 1'b1;
    tick();
    dready = 1'b0;
    n_cmp++;
    if ({dvalid, busy, enb, dout} !== {1'b0, 1'b0, 1'b1, 8'hA5}) begin
      n_err++;
      $display("FAIL basic_accept: dvalid/busy/enb/dout got %b%b%b/%h required 001/a5",
               dvalid, busy, enb, dout);
    end
  endtask

  task automatic test_backpressure();
    run_scan(8'hA5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({dvalid, busy, dout} !== {1'b1, 1'b1, 8'hA5}) begin
        n_err++;
        $display("FAIL backpressure i=%0d: dvalid/busy/dout got %b%b/%h required 11/a5",
                 i, dvalid, busy, dout);
      end
    end
    dready = 1'b1;
    tick();
    dready = 1'b0;
    n_cmp++;
    if ({dvalid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL bp_release: dvalid/busy got %b%b required 00", dvalid, busy);
    end
    tick();
    n_cmp++;
    if ({dvalid, busy, enb} !== 3'b001) begin
      n_err++;
      $display("FAIL bp_idle: dvalid/busy/enb got %b%b%b required 001", dvalid, busy, enb);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pats [2];
    int n;
    pats[0] = 8'h3C;
    pats[1] = 8'hC3;
    d_model = pats[0];
    start  = 1'b1;
    dready = 1'b1;
    tick();
    for (int s = 0; s < 2; s++) begin
      n = 0;
      while (dvalid !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      n_cmp++;
      if (n !== LAT || dout !== pats[s]) begin
        n_err++;
        $display("FAIL b2b_byte s=%0d: latency/dout got %0d/%h required %0d/%h",
                 s, n, dout, LAT, pats[s]);
      end
      if (s == 0) begin
        d_model = pats[1];
        tick();
        n_cmp++;
        if ({dvalid, busy, enb, sel} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
          n_err++;
          $display("FAIL b2b_restart: dvalid/busy/enb/sel got %b%b%b/%0d required 010/0",
                   dvalid, busy, enb, sel);
        end
      end
    end
    start = 1'b0;
    tick();
    dready = 1'b0;
    n_cmp++;
    if ({dvalid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_end: dvalid/busy got %b%b required 00", dvalid, busy);
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] data;
    int n;
    int bad;
    data    = 8'($urandom) | 8'h01;
    d_model = data;
    start   = 1'b1;
    tick();
    n = 0;
    while (dvalid !== 1'b1 && n < 40) begin
      start = (n == 4);
      tick();
      n++;
    end
    start = 1'b0;
    n_cmp++;
    if (n !== LAT || dout !== data) begin
      n_err++;
      $display("FAIL ignore_latency: latency/dout got %0d/%h required %0d/%h", n, dout, LAT, data);
    end
    dready = 1'b1;
    tick();
    dready = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (dvalid !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL ignore_no_rescan: busy-or-valid cycles got %0d required 0", bad);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [7:0] data;
    d_model = 8'h5A;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4 * PER; i++) tick();
    n_cmp++;
    if (sel !== 3'd4) begin
      n_err++;
      $display("FAIL midscan_sel: sel got %0d required 4", sel);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy, sel, enb, dout, dvalid} !== {1'b0, 3'd0, 1'b1, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL midscan_reset: busy/sel/enb/dout/dvalid got %b/%0d/%b/%h/%b required 0/0/1/00/0",
               busy, sel, enb, dout, dvalid);
    end
    tick();
    data = 8'($urandom);
    run_scan(data, 1'b1);
    dready = 1'b1;
    tick();
    dready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] data;
    int r;
    for (int it = 0; it < 8; it++) begin
      data = 8'($urandom);
      run_scan(data, 1'b1);
      r = $urandom_range(0, 5);
      for (int i = 0; i < r; i++) begin
        tick();
        n_cmp++;
        if ({dvalid, dout} !== {1'b1, data}) begin
          n_err++;
          $display("FAIL rand_hold it=%0d: dvalid/dout got %b/%h required 1/%h", it, dvalid, dout, data);
        end
      end
      dready = 1'b1;
      tick();
      dready = 1'b0;
      n_cmp++;
      if ({dvalid, busy, dout} !== {1'b0, 1'b0, data}) begin
        n_err++;
        $display("FAIL rand_accept it=%0d: dvalid/busy/dout got %b%b/%h required 00/%h",
                 it, dvalid, busy, dout, data);
      end
      tick();
    end
  endtask

  task automatic test_settle1();
    logic [7:0] pats [2];
    int n;
    pats[0] = 8'hFF;
    pats[1] = 8'h00;
    for (int s = 0; s < 2; s++) begin
      d2_model = pats[s];
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      n = 0;
      while (dvalid2 !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      n_cmp++;
      if (n !== LAT2 || dout2 !== pats[s]) begin
        n_err++;
        $display("FAIL settle1 s=%0d: latency/dout got %0d/%h required %0d/%h",
                 s, n, dout2, LAT2, pats[s]);
      end
      dready2 = 1'b1;
      tick();
      dready2 = 1'b0;
      n_cmp++;
      if ({dvalid2, busy2} !== 2'b00) begin
        n_err++;
        $display("FAIL settle1_accept s=%0d: dvalid/busy got %b%b required 00", s, dvalid2, busy2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_scan();
    test_random();
    test_settle1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
